// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared geometry, state enum and slot helper for the icache refill engine
//
// Purpose: constants describing the 1 KB direct-mapped instruction cache
//          (32 lines x 256 bits, addr = {tag[23:0], index[4:0], offset[2:0]}),
//          the refill FSM state type, and the word-slot bit-position helper.
// Ports:   none (package).
package icache_pkg;

  localparam int TAG_W    = 24;
  localparam int INDEX_W  = 5;
  localparam int OFFSET_W = 3;
  localparam int WORD_W   = 32;
  localparam int LINE_W   = WORD_W << OFFSET_W;
  localparam int WORDS    = 1 << OFFSET_W;
  localparam int LINES    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } refill_state_e;

  // Word 0 sits in the most significant slot: word w is bits [255-32w : 224-32w].
  function automatic int word_lsb(input int slot);
    return LINE_W - WORD_W * (slot + 1);
  endfunction

endpackage

// File: rtl/icache_line_buf.sv
// rtl/icache_line_buf.sv - 8 x 32-bit slot register assembling one cache line
//
// Purpose: holds the words of the line being refilled; one slot written per
//          cycle, all slots presented as a flat 256-bit line.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset (clears all slots)
//   wr_en    in   write wr_data into slot wr_slot this cycle
//   wr_slot  in   3-bit slot select (word offset within the line)
//   wr_data  in   32-bit word
//   line     out  256-bit assembled line, word 0 in bits [255:224]
module icache_line_buf
  import icache_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [OFFSET_W-1:0] wr_slot,
  input  logic [WORD_W-1:0]   wr_data,
  output logic [LINE_W-1:0]   line
);

  logic [WORD_W-1:0] slot_q [WORDS];
  logic [WORD_W-1:0] slot_d [WORDS];

  always_comb begin
    for (int i = 0; i < WORDS; i++) begin
      slot_d[i] = slot_q[i];
    end
    if (wr_en) begin
      slot_d[wr_slot] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WORDS; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  always_comb begin
    line = '0;
    for (int i = 0; i < WORDS; i++) begin
      line[word_lsb(i) +: WORD_W] = slot_q[i];
    end
  end

endmodule

// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - line-fill engine writing refilled lines into the icache arrays
//
// Purpose: accepts a miss address, reads the 8 words of the line over a
//          req/ack memory handshake, then issues a one-cycle line write.
// Build option: ICACHE_REFILL_CWF_EN enables critical-word-first ordering and
//          the crit_valid/crit_word outputs; undefined, words are fetched 0..7.
// Ports:
//   clk, reset              clock; asynchronous active-low reset
//   miss_valid/miss_addr    miss request from fetch; miss_ready high only in IDLE
//   flush                   aborts an in-flight fetch (no write issued)
//   mem_req/mem_addr        memory read request, address {tag, index, beat}
//   mem_ack/mem_rdata       memory returns a word
//   line_we, line_index, line_tag, line_data, line_valid
//                           one-cycle write to the tag/data/valid arrays
//   refill_done             pulse coincident with line_we
//   busy                    high whenever not IDLE
//   crit_valid/crit_word    (CWF build) pulse and word of the first returned beat
module icache_refill
  import icache_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               miss_valid,
  input  logic [31:0]        miss_addr,
  output logic               miss_ready,
  input  logic               flush,
  output logic               mem_req,
  output logic [31:0]        mem_addr,
  input  logic               mem_ack,
  input  logic [WORD_W-1:0]  mem_rdata,
  output logic               line_we,
  output logic [INDEX_W-1:0] line_index,
  output logic [TAG_W-1:0]   line_tag,
  output logic [LINE_W-1:0]  line_data,
  output logic               line_valid,
  output logic               refill_done,
  output logic               busy
`ifdef ICACHE_REFILL_CWF_EN
  ,
  output logic               crit_valid,
  output logic [WORD_W-1:0]  crit_word
`endif
);

  refill_state_e       state_q, state_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [INDEX_W-1:0]  index_q, index_d;
  logic [OFFSET_W-1:0] beat_q, beat_d;
  logic [OFFSET_W-1:0] count_q, count_d;
  logic                buf_we;
  logic [OFFSET_W-1:0] start_beat;

`ifdef ICACHE_REFILL_CWF_EN
  logic                crit_valid_q, crit_valid_d;
  logic [WORD_W-1:0]   crit_word_q, crit_word_d;

  assign start_beat = miss_addr[OFFSET_W-1:0];
`else
  logic                unused_miss_offset;

  assign start_beat         = '0;
  assign unused_miss_offset = ^miss_addr[OFFSET_W-1:0];
`endif

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    index_d = index_q;
    beat_d  = beat_q;
    count_d = count_q;
    buf_we  = 1'b0;
`ifdef ICACHE_REFILL_CWF_EN
    crit_valid_d = 1'b0;
    crit_word_d  = crit_word_q;
`endif
    case (state_q)
      IDLE: begin
        // flush is deliberately not consulted here so it cannot block an accept.
        if (miss_valid) begin
          tag_d   = miss_addr[31 -: TAG_W];
          index_d = miss_addr[OFFSET_W +: INDEX_W];
          beat_d  = start_beat;
          count_d = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        // flush wins over a same-cycle ack; the partial line is simply never written.
        if (flush) begin
          state_d = IDLE;
        end else if (mem_ack) begin
          buf_we  = 1'b1;
          beat_d  = beat_q + 1'b1;
          count_d = count_q + 1'b1;
`ifdef ICACHE_REFILL_CWF_EN
          if (count_q == '0) begin
            crit_valid_d = 1'b1;
            crit_word_d  = mem_rdata;
          end
`endif
          if (count_q == '1) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tag_q   <= '0;
      index_q <= '0;
      beat_q  <= '0;
      count_q <= '0;
`ifdef ICACHE_REFILL_CWF_EN
      crit_valid_q <= 1'b0;
      crit_word_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      index_q <= index_d;
      beat_q  <= beat_d;
      count_q <= count_d;
`ifdef ICACHE_REFILL_CWF_EN
      crit_valid_q <= crit_valid_d;
      crit_word_q  <= crit_word_d;
`endif
    end
  end

  // Slot placement is by word offset (beat), independent of fetch order.
  icache_line_buf u_line_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (buf_we),
    .wr_slot (beat_q),
    .wr_data (mem_rdata),
    .line    (line_data)
  );

  assign miss_ready  = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign mem_req     = (state_q == FETCH);
  assign mem_addr    = {tag_q, index_q, beat_q};
  assign line_we     = (state_q == WRITE);
  assign line_valid  = (state_q == WRITE);
  assign refill_done = (state_q == WRITE);
  assign line_index  = index_q;
  assign line_tag    = tag_q;

`ifdef ICACHE_REFILL_CWF_EN
  assign crit_valid = crit_valid_q;
  assign crit_word  = crit_word_q;
`endif

endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - directed self-checking bench for icache_refill
module tb_icache_refill;

  logic         clk;
  logic         reset;
  logic         miss_valid;
  logic [31:0]  miss_addr;
  logic         miss_ready;
  logic         flush;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;
  logic         line_we;
  logic [4:0]   line_index;
  logic [23:0]  line_tag;
  logic [255:0] line_data;
  logic         line_valid;
  logic         refill_done;
  logic         busy;
`ifdef ICACHE_REFILL_CWF_EN
  logic         crit_valid;
  logic [31:0]  crit_word;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;
  int we_cnt    = 0;

  icache_refill dut (
    .clk         (clk),
    .reset       (reset),
    .miss_valid  (miss_valid),
    .miss_addr   (miss_addr),
    .miss_ready  (miss_ready),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .line_we     (line_we),
    .line_index  (line_index),
    .line_tag    (line_tag),
    .line_data   (line_data),
    .line_valid  (line_valid),
    .refill_done (refill_done),
    .busy        (busy)
`ifdef ICACHE_REFILL_CWF_EN
    ,
    .crit_valid  (crit_valid),
    .crit_word   (crit_word)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (line_we === 1'b1) we_cnt++;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A00_00A5;
  endfunction

  function automatic logic [255:0] mline(input logic [31:0] a);
    logic [255:0] l;
    l = '0;
    for (int w = 0; w < 8; w++) begin
      l[255 - 32*w -: 32] = mdata({a[31:3], 3'(w)});
    end
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic refill(input logic [31:0] a, input bit stall, input string nm);
    logic [2:0]  beat;
    logic [31:0] ea;
    int          ns;
`ifdef ICACHE_REFILL_CWF_EN
    beat = a[2:0];
`else
    beat = 3'd0;
`endif
    miss_valid = 1'b1;
    miss_addr  = a;
    mem_ack    = 1'b0;
    step();
    miss_valid = 1'b0;
    check({nm, "_busy"}, 256'(busy), 256'd1);
    for (int b = 0; b < 8; b++) begin
      ea = {a[31:3], beat};
      if (stall) begin
        ns = $urandom_range(0, 3);
        for (int s = 0; s < ns; s++) begin
          mem_ack = 1'b0;
          step();
          check({nm, "_stall_req"}, 256'(mem_req), 256'd1);
          check({nm, "_stall_addr"}, 256'(mem_addr), 256'(ea));
        end
      end
      check({nm, "_req"}, 256'(mem_req), 256'd1);
      check({nm, "_addr"}, 256'(mem_addr), 256'(ea));
      check({nm, "_no_we"}, 256'(line_we), 256'd0);
      mem_ack   = 1'b1;
      mem_rdata = mdata(ea);
      step();
`ifdef ICACHE_REFILL_CWF_EN
      if (b == 0) begin
        check({nm, "_crit_valid"}, 256'(crit_valid), 256'd1);
        check({nm, "_crit_word"}, 256'(crit_word), 256'(mdata(ea)));
      end
`endif
      beat = beat + 3'd1;
    end
    mem_ack = 1'b0;
    check({nm, "_we"}, 256'(line_we), 256'd1);
    check({nm, "_done"}, 256'(refill_done), 256'd1);
    check({nm, "_valid"}, 256'(line_valid), 256'd1);
    check({nm, "_index"}, 256'(line_index), 256'(a[7:3]));
    check({nm, "_tag"}, 256'(line_tag), 256'(a[31:8]));
    check({nm, "_data"}, line_data, mline(a));
    step();
    check({nm, "_we_drop"}, 256'(line_we), 256'd0);
    check({nm, "_ready"}, 256'(miss_ready), 256'd1);
  endtask

  initial begin
    reset      = 1'b0;
    miss_valid = 1'b0;
    miss_addr  = '0;
    flush      = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    #1;
    check("rst_ready", 256'(miss_ready), 256'd1);
    check("rst_req", 256'(mem_req), 256'd0);
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_we", 256'(line_we), 256'd0);
    check("rst_addr", 256'(mem_addr), 256'd0);
    check("rst_data", line_data, 256'd0);
    step();
    step();
    reset = 1'b1;
    step();

    // Basic refill, ack always high: index 7, tag 0x12, addresses 0x1238..0x123F.
    refill(32'h0000_1238, 1'b0, "basic");
    check("basic_index_hand", 256'(line_index), 256'd7);
    check("basic_tag_hand", 256'(line_tag), 256'h12);
    check("basic_we_cnt", 256'(we_cnt), 256'd1);

    // Random ack stalls, nonzero miss offset.
    refill(32'h0000_567E, 1'b1, "stall");
    check("stall_we_cnt", 256'(we_cnt), 256'd2);

    // Flush after the 4th ack with a simultaneous ack.
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_4A10;
    step();
    miss_valid = 1'b0;
    mem_ack    = 1'b1;
    for (int b = 0; b < 4; b++) begin
      mem_rdata = mdata({29'(32'h4A10 >> 3), 3'(b)});
      step();
    end
    check("flush_addr_b4", 256'(mem_addr), 256'h4A14);
    flush = 1'b1;
    step();
    flush   = 1'b0;
    mem_ack = 1'b0;
    check("flush_busy", 256'(busy), 256'd0);
    check("flush_ready", 256'(miss_ready), 256'd1);
    check("flush_req", 256'(mem_req), 256'd0);
    check("flush_we", 256'(line_we), 256'd0);
    step();
    check("flush_we_cnt", 256'(we_cnt), 256'd2);
    refill(32'h00AB_CDE0, 1'b0, "post_flush");
    check("post_flush_we_cnt", 256'(we_cnt), 256'd3);

    // Reset asserted at beat 5.
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_7770;
    step();
    miss_valid = 1'b0;
    mem_ack    = 1'b1;
    for (int b = 0; b < 5; b++) begin
      mem_rdata = mdata({29'(32'h7770 >> 3), 3'(b)});
      step();
    end
    check("rstmid_addr_b5", 256'(mem_addr), 256'h7775);
    reset = 1'b0;
    #1;
    check("rstmid_req", 256'(mem_req), 256'd0);
    check("rstmid_busy", 256'(busy), 256'd0);
    check("rstmid_ready", 256'(miss_ready), 256'd1);
    check("rstmid_addr", 256'(mem_addr), 256'd0);
    check("rstmid_data", line_data, 256'd0);
    check("rstmid_tag", 256'(line_tag), 256'd0);
    check("rstmid_we", 256'(line_we), 256'd0);
    step();
    step();
    reset   = 1'b1;
    mem_ack = 1'b0;
    step();
    step();
    step();
    check("rstmid_after_busy", 256'(busy), 256'd0);
    check("rstmid_we_cnt", 256'(we_cnt), 256'd3);

    // miss_valid held during busy: second miss taken the cycle after WRITE.
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_2040;
    step();
    miss_addr = 32'h0000_3058;
    mem_ack   = 1'b1;
    for (int b = 0; b < 8; b++) begin
      check("held_a_addr", 256'(mem_addr), 256'({29'(32'h2040 >> 3), 3'(b)}));
      mem_rdata = mdata({29'(32'h2040 >> 3), 3'(b)});
      step();
    end
    check("held_a_we", 256'(line_we), 256'd1);
    check("held_a_tag", 256'(line_tag), 256'h20);
    check("held_a_index", 256'(line_index), 256'd8);
    check("held_a_data", line_data, mline(32'h0000_2040));
    step();
    check("held_idle_ready", 256'(miss_ready), 256'd1);
    check("held_idle_we", 256'(line_we), 256'd0);
    step();
    check("held_b_busy", 256'(busy), 256'd1);
    check("held_b_addr", 256'(mem_addr), 256'h3058);
    miss_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      mem_rdata = mdata({29'(32'h3058 >> 3), 3'(b)});
      step();
    end
    mem_ack = 1'b0;
    check("held_b_we", 256'(line_we), 256'd1);
    check("held_b_tag", 256'(line_tag), 256'h30);
    check("held_b_index", 256'(line_index), 256'd11);
    check("held_b_data", line_data, mline(32'h0000_3058));
    step();
    check("held_we_cnt", 256'(we_cnt), 256'd5);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
